// File: rtl/id_decode_stage_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate-type encodings and
// the decoded-field bundle carried through the ID/EX pipeline register.
package id_decode_stage_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_INST = 25;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Encoding shared with the EX-stage immediate generator.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    imm_sel_e   imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [6:0] opcode;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and EX-side handshake/bus signals of the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface id_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int INST = 25
);

  logic            if_valid_i;
  logic            if_ready_o;
  logic [31:0]     if_inst_i;
  logic [XLEN-1:0] if_pc_i;
  logic            flush_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] ex_pc_o;
  logic [INST-1:0] IMM_o;
  logic [2:0]      IMM_sel_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [2:0]      funct3_o;
  logic            funct7b5_o;
  logic [6:0]      opcode_o;
  logic            illegal_o;

  modport slave (
    input  if_valid_i, if_inst_i, if_pc_i, flush_i, ex_ready_i,
    output if_ready_o, ex_valid_o, ex_pc_o, IMM_o, IMM_sel_o,
           rs1_o, rs2_o, rd_o, funct3_o, funct7b5_o, opcode_o, illegal_o
  );

  modport master (
    output if_valid_i, if_inst_i, if_pc_i, flush_i, ex_ready_i,
    input  if_ready_o, ex_valid_o, ex_pc_o, IMM_o, IMM_sel_o,
           rs1_o, rs2_o, rd_o, funct3_o, funct7b5_o, opcode_o, illegal_o
  );

endinterface

// File: rtl/id_decode_stage_opcode_decoder.sv
// Combinational RV32I opcode classifier: immediate-type select and illegal flag.
module id_decode_stage_opcode_decoder
  import id_decode_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_sel_e   imm_sel_o,
  output logic       illegal_o
);

  // Opcode to immediate format; anything outside the base set is flagged.
  always_comb begin
    imm_sel_o = IMM_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LUI,
      OPC_AUIPC:    imm_sel_o = IMM_U;
      OPC_JAL:      imm_sel_o = IMM_J;
      OPC_JALR,
      OPC_LOAD,
      OPC_OP_IMM,
      OPC_SYSTEM:   imm_sel_o = IMM_I;
      OPC_BRANCH:   imm_sel_o = IMM_B;
      OPC_STORE:    imm_sel_o = IMM_S;
      OPC_OP,
      OPC_MISC_MEM: imm_sel_o = IMM_NONE;
      default: begin
        imm_sel_o = IMM_NONE;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: single-entry valid/ready pipeline register
// holding the fetched PC plus its decoded fields, with EX back-pressure and flush.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int INST = DEF_INST
) (
  input logic               clk_i,
  input logic               rst_n_i,
  id_decode_stage_if.slave  bus
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [INST-1:0] imm_q, imm_d;
  dec_t            dec_q, dec_d;

  logic            ready_s;
  logic            accept_s;
  logic            transfer_s;
  logic            load_s;
  imm_sel_e        opc_imm_sel_s;
  logic            opc_illegal_s;

  id_decode_stage_opcode_decoder u_opcode_decoder (
    .opcode_i  (bus.if_inst_i[6:0]),
    .imm_sel_o (opc_imm_sel_s),
    .illegal_o (opc_illegal_s)
  );

  // Handshake terms; a flush always drains the fetch beat so it can be dropped.
  always_comb begin
    ready_s    = ~valid_q | bus.ex_ready_i | bus.flush_i;
    accept_s   = bus.if_valid_i & ready_s;
    transfer_s = valid_q & bus.ex_ready_i;
    load_s     = accept_s & ~bus.flush_i;
  end

  // Next valid: flush wins, then a new accept, then a drain to EX.
  always_comb begin
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
    end else if (transfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Data path loads only on a surviving accept so a stalled beat stays frozen.
  always_comb begin
    pc_d  = pc_q;
    imm_d = imm_q;
    dec_d = dec_q;
    if (load_s) begin
      pc_d           = bus.if_pc_i;
      imm_d          = bus.if_inst_i[31:7];
      dec_d.imm_sel  = opc_imm_sel_s;
      dec_d.rs1      = bus.if_inst_i[19:15];
      dec_d.rs2      = bus.if_inst_i[24:20];
      dec_d.rd       = bus.if_inst_i[11:7];
      dec_d.funct3   = bus.if_inst_i[14:12];
      dec_d.funct7b5 = bus.if_inst_i[30];
      dec_d.opcode   = bus.if_inst_i[6:0];
      dec_d.illegal  = opc_illegal_s;
    end else begin
      pc_d  = pc_q;
      imm_d = imm_q;
      dec_d = dec_q;
    end
  end

  // Pipeline register; reset drops any held instruction immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.if_ready_o = ready_s;
  assign bus.ex_valid_o = valid_q;
  assign bus.ex_pc_o    = pc_q;
  assign bus.IMM_o      = imm_q;
  assign bus.IMM_sel_o  = dec_q.imm_sel;
  assign bus.rs1_o      = dec_q.rs1;
  assign bus.rs2_o      = dec_q.rs2;
  assign bus.rd_o       = dec_q.rd;
  assign bus.funct3_o   = dec_q.funct3;
  assign bus.funct7b5_o = dec_q.funct7b5;
  assign bus.opcode_o   = dec_q.opcode;
  assign bus.illegal_o  = dec_q.illegal;

endmodule
